io_pins_readback: RTL and testbench

//  Read-side companion to the GPIO output-enable block: samples the four 16-bit

---
 rtl/io_pins_readback_pkg.sv | 27 ++
 rtl/io_pins_readback_if.sv | 26 ++
 rtl/io_pins_readback_bank_capture.sv | 61 ++++++
 rtl/io_pins_readback.sv | 128 ++++++++++++
 tb/tb_io_pins_readback.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pins_readback_pkg.sv
`timescale 1ns/1ps
// io_pins_readback_pkg
//   Shared types and register addresses for the io_pins_readback block.
//   The FR_IO_* addresses sit in the free marine-radar range of the FPGA
//   register map.
package io_pins_readback_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned BANK_W    = 16;

  typedef logic [BANK_W-1:0] bank_t;

  typedef enum logic [6:0] {
    FR_IO_EDGE_0 = 7'd88,
    FR_IO_EDGE_1 = 7'd89,
    FR_IO_EDGE_2 = 7'd90,
    FR_IO_EDGE_3 = 7'd91,
    FR_IO_CLR    = 7'd92,
    FR_IO_IRQ_EN = 7'd93
  } fr_addr_e;

  // Readback word layout: sticky edges in the upper half, live pins below.
  function automatic logic [31:0] resp_word(input bank_t sticky, input bank_t live);
    return {sticky, live};
  endfunction

endpackage

// File: rtl/io_pins_readback_if.sv
`timescale 1ns/1ps
// io_pins_readback_if
//   Host-side bus of io_pins_readback: serial config write port, one-cycle
//   read handshake and the summary interrupt.
//   master: drives serial_* and rd_req/rd_bank; receives rd_valid/rd_data/irq.
//   slave : the readback block.
interface io_pins_readback_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        rd_req;
  logic [1:0]  rd_bank;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        irq;

  modport master (
    output serial_addr, serial_data, serial_strobe, rd_req, rd_bank,
    input  rd_valid, rd_data, irq
  );

  modport slave (
    input  serial_addr, serial_data, serial_strobe, rd_req, rd_bank,
    output rd_valid, rd_data, irq
  );
endinterface

// File: rtl/io_pins_readback_bank_capture.sv
`timescale 1ns/1ps
// io_bank_capture
//   One 16-bit io bank: synchroniser chain, previous-sample register,
//   enabled rise/fall edge detect and sticky edge register.
//   Ports:
//     clock, reset_n  system clock, async active-low reset
//     pad             raw pad values (asynchronous to clock)
//     rise_en/fall_en per-bit edge enables
//     clr             per-bit sticky clear mask for this cycle
//     live            last synchroniser stage
//     sticky          accumulated enabled edges
module io_bank_capture
  import io_pins_readback_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic  clock,
  input  logic  reset_n,
  input  bank_t pad,
  input  bank_t rise_en,
  input  bank_t fall_en,
  input  bank_t clr,
  output bank_t live,
  output bank_t sticky
);

  bank_t sync_q [SYNC_STAGES];
  bank_t sync_d [SYNC_STAGES];
  bank_t prev_q, prev_d;
  bank_t sticky_q, sticky_d;
  bank_t edge_det;

  assign live   = sync_q[SYNC_STAGES-1];
  assign sticky = sticky_q;

  always_comb begin
    sync_d[0] = pad;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d   = live;
    edge_det = (live & ~prev_q & rise_en) | (~live & prev_q & fall_en);
    // New edges are OR'd in after the clear so a same-cycle set always survives.
    sticky_d = (sticky_q & ~clr) | edge_det;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q   <= '0;
      sticky_q <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: rtl/io_pins_readback.sv
`timescale 1ns/1ps
// io_pins_readback
//   Read-side companion of the GPIO output-enable block. Samples the four
//   16-bit daughterboard io banks, latches enabled edges into sticky bits and
//   returns {sticky, live} on a one-cycle read handshake (read clears the
//   returned sticky bits). irq is high while any enabled bank has sticky set.
//   Ports:
//     clock, reset_n  system clock, async active-low reset
//     io_0..io_3      raw pad banks
//     bus             config writes, read handshake, irq (slave modport)
module io_pins_readback
  import io_pins_readback_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] io_0,
  input  logic [15:0] io_1,
  input  logic [15:0] io_2,
  input  logic [15:0] io_3,
  io_pins_readback_if.slave bus
);

  bank_t pads   [NUM_BANKS];
  bank_t live   [NUM_BANKS];
  bank_t sticky [NUM_BANKS];
  bank_t clr    [NUM_BANKS];

  bank_t rise_en_q [NUM_BANKS];
  bank_t rise_en_d [NUM_BANKS];
  bank_t fall_en_q [NUM_BANKS];
  bank_t fall_en_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] irq_en_q, irq_en_d;

  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        irq_q, irq_d;

  assign pads[0] = io_0;
  assign pads[1] = io_1;
  assign pads[2] = io_2;
  assign pads[3] = io_3;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    io_bank_capture #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_capture (
      .clock   (clock),
      .reset_n (reset_n),
      .pad     (pads[k]),
      .rise_en (rise_en_q[k]),
      .fall_en (fall_en_q[k]),
      .clr     (clr[k]),
      .live    (live[k]),
      .sticky  (sticky[k])
    );
  end

  // Config decode: edge registers are full overwrites, unknown addresses ignored.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    if (bus.serial_strobe) begin
      case (bus.serial_addr)
        FR_IO_EDGE_0: begin rise_en_d[0] = bus.serial_data[31:16]; fall_en_d[0] = bus.serial_data[15:0]; end
        FR_IO_EDGE_1: begin rise_en_d[1] = bus.serial_data[31:16]; fall_en_d[1] = bus.serial_data[15:0]; end
        FR_IO_EDGE_2: begin rise_en_d[2] = bus.serial_data[31:16]; fall_en_d[2] = bus.serial_data[15:0]; end
        FR_IO_EDGE_3: begin rise_en_d[3] = bus.serial_data[31:16]; fall_en_d[3] = bus.serial_data[15:0]; end
        FR_IO_IRQ_EN: irq_en_d = bus.serial_data[NUM_BANKS-1:0];
        default: ;
      endcase
    end
  end

  // Clear-mask merge: the read clears exactly the bits it returns, and an
  // explicit FR_IO_CLR to the same bank in the same cycle ORs in.
  always_comb begin
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      clr[k] = '0;
      if (bus.rd_req && (bus.rd_bank == 2'(k))) begin
        clr[k] = sticky[k];
      end
      if (bus.serial_strobe && (bus.serial_addr == FR_IO_CLR) &&
          (bus.serial_data[17:16] == 2'(k))) begin
        clr[k] = clr[k] | bus.serial_data[15:0];
      end
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_data_d  = rd_data_q;
    if (bus.rd_req) begin
      rd_data_d = resp_word(sticky[bus.rd_bank], live[bus.rd_bank]);
    end
    irq_d = 1'b0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      irq_d = irq_d | ((sticky[k] != '0) && irq_en_q[k]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_BANKS; k++) begin
        rise_en_q[k] <= '0;
        fall_en_q[k] <= '0;
      end
      irq_en_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_en_q   <= irq_en_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_io_pins_readback.sv
`timescale 1ns/1ps
// tb_io_pins_readback
//   Scenario-per-task bench for io_pins_readback. Expected read responses are
//   queued when a request is driven and popped when rd_valid appears.
module tb_io_pins_readback;
  import io_pins_readback_pkg::*;

  localparam int unsigned SYNC_STAGES = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] io_0, io_1, io_2, io_3;

  io_pins_readback_if bus ();

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_word;

  always #5 clock = ~clock;

  io_pins_readback #(
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io_0    (io_0),
    .io_1    (io_1),
    .io_2    (io_2),
    .io_3    (io_3),
    .bus     (bus)
  );

  // All stimulus tasks start and end just after a falling edge.
  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg_write(input logic [6:0] addr, input logic [31:0] data);
    bus.serial_addr   = addr;
    bus.serial_data   = data;
    bus.serial_strobe = 1'b1;
    @(negedge clock);
    bus.serial_strobe = 1'b0;
    bus.serial_addr   = '0;
    bus.serial_data   = '0;
  endtask

  task automatic pulse_read(input logic [1:0] bank, input logic [31:0] exp);
    bus.rd_req  = 1'b1;
    bus.rd_bank = bank;
    sb.push_back(exp);
    @(negedge clock);
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_checks++;
    if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00000000", bus.rd_data); end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    reset_n = 1'b1;
    idle(SYNC_STAGES + 2);
    for (int b = 0; b < 4; b++) begin
      pulse_read(2'(b), 32'h0000_0000);
      n_checks++;
      if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL reset_read_valid bank%0d: rd_valid=%b queued=%0d want 1", b, bus.rd_valid, sb.size()); sb.delete();
      end else begin
        exp_word = sb.pop_front(); n_checks++;
        if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL reset_read_data bank%0d: got %h want %h", b, bus.rd_data, exp_word); end
      end
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after: got %b want 0", bus.irq); end
  endtask

  task automatic test_rise_irq();
    cfg_write(FR_IO_EDGE_0, 32'h0001_0000);
    cfg_write(FR_IO_IRQ_EN, 32'h0000_0001);
    io_0[0] = 1'b1;
    // sticky at SYNC_STAGES+1 edges, irq one edge later
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      idle(1);
      n_checks++;
      if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early cyc%0d: got %b want 0", k, bus.irq); end
    end
    idle(1);
    n_checks++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq_set: got %b want 1", bus.irq); end
    pulse_read(2'd0, 32'h0001_0001);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL rise_read1_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL rise_read1_data: got %h want %h", bus.rd_data, exp_word); end
    end
    idle(1);
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_cleared: got %b want 0", bus.irq); end
    pulse_read(2'd0, 32'h0000_0001);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL rise_read2_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL rise_read2_data: got %h want %h", bus.rd_data, exp_word); end
    end
  endtask

  task automatic test_fall_clear();
    io_2[7] = 1'b1;
    idle(SYNC_STAGES + 2);
    cfg_write(FR_IO_EDGE_2, 32'h0000_0080);
    cfg_write(FR_IO_IRQ_EN, 32'h0000_0004);
    io_2[7] = 1'b0;
    idle(SYNC_STAGES + 2);
    n_checks++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL fall_irq_set: got %b want 1", bus.irq); end
    cfg_write(FR_IO_CLR, 32'h0002_0080);
    pulse_read(2'd2, 32'h0000_0000);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL fall_read_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL fall_read_data: got %h want %h", bus.rd_data, exp_word); end
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL fall_irq_cleared: got %b want 0", bus.irq); end
  endtask

  task automatic test_edge_during_read();
    cfg_write(FR_IO_EDGE_1, 32'h0008_0000);
    io_1[3] = 1'b1;
    // live rises after SYNC_STAGES edges; the edge cycle is the one after that
    idle(SYNC_STAGES);
    pulse_read(2'd1, 32'h0000_0008);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL coinc_read1_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL coinc_read1_data: got %h want %h", bus.rd_data, exp_word); end
    end
    pulse_read(2'd1, 32'h0008_0008);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL coinc_read2_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL coinc_read2_data: got %h want %h", bus.rd_data, exp_word); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h0000_A5A5;
    exp_tab[1] = 32'h0000_1234;
    exp_tab[2] = 32'h0000_00F0;
    exp_tab[3] = 32'hFFFF_FFFF;
    cfg_write(FR_IO_EDGE_0, 32'h0);
    cfg_write(FR_IO_EDGE_1, 32'h0);
    cfg_write(FR_IO_EDGE_2, 32'h0);
    cfg_write(FR_IO_EDGE_3, 32'hFFFF_0000);
    cfg_write(FR_IO_IRQ_EN, 32'h0000_0008);
    io_0 = 16'hA5A5; io_1 = 16'h1234; io_2 = 16'h00F0; io_3 = 16'hFFFF;
    idle(SYNC_STAGES + 3);
    n_checks++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq_bank3: got %b want 1", bus.irq); end
    // disabling the edge must not drop bits already sticky
    cfg_write(FR_IO_EDGE_3, 32'h0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_bank = 2'(i);
      sb.push_back(exp_tab[i]);
      @(negedge clock);
      n_checks++;
      if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_valid req%0d: rd_valid=%b queued=%0d want 1", i, bus.rd_valid, sb.size()); sb.delete();
      end else begin
        exp_word = sb.pop_front(); n_checks++;
        if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL b2b_data req%0d: got %h want %h", i, bus.rd_data, exp_word); end
      end
    end
    bus.rd_req = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b want 0", bus.rd_valid); end
    n_checks++;
    if (bus.rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_data_hold: got %h want ffffffff", bus.rd_data); end
    pulse_read(2'd3, 32'h0000_FFFF);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL b2b_reread_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL b2b_reread_data: got %h want %h", bus.rd_data, exp_word); end
    end
  endtask

  task automatic test_reset_mid_read();
    cfg_write(FR_IO_EDGE_0, 32'hFFFF_0000);
    cfg_write(FR_IO_IRQ_EN, 32'h0000_000F);
    bus.rd_req  = 1'b1;
    bus.rd_bank = 2'd0;
    #2;
    reset_n     = 1'b0;
    bus.rd_req  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid cyc%0d: got %b want 0", k, bus.rd_valid); end
    end
    reset_n = 1'b1;
    // sync chain restarts from zero, so an immediate read sees live = 0
    pulse_read(2'd0, 32'h0000_0000);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL midrst_read1_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL midrst_read1_data: got %h want %h", bus.rd_data, exp_word); end
    end
    io_0 = 16'h5A5A;
    idle(SYNC_STAGES + 3);
    pulse_read(2'd0, 32'h0000_5A5A);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL midrst_read2_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL midrst_read2_data: got %h want %h", bus.rd_data, exp_word); end
    end
    // with irq_en cleared by reset, a fresh sticky edge must not raise irq
    cfg_write(FR_IO_EDGE_0, 32'h0000_FFFF);
    io_0 = 16'h0000;
    idle(SYNC_STAGES + 3);
    n_checks++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq_en_cleared: got %b want 0", bus.irq); end
    pulse_read(2'd0, 32'h5A5A_0000);
    n_checks++;
    if (bus.rd_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL midrst_read3_valid: rd_valid=%b queued=%0d want 1", bus.rd_valid, sb.size()); sb.delete();
    end else begin
      exp_word = sb.pop_front(); n_checks++;
      if (bus.rd_data !== exp_word) begin n_fail++; $display("FAIL midrst_read3_data: got %h want %h", bus.rd_data, exp_word); end
    end
  endtask

  initial begin
    io_0 = '0; io_1 = '0; io_2 = '0; io_3 = '0;
    bus.serial_addr   = '0;
    bus.serial_data   = '0;
    bus.serial_strobe = 1'b0;
    bus.rd_req        = 1'b0;
    bus.rd_bank       = '0;
    @(negedge clock);
    test_reset();
    test_rise_irq();
    test_fall_clear();
    test_edge_during_read();
    test_back_to_back();
    test_reset_mid_read();
    idle(2);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
